// File: rtl/ex_muldiv_unit_if.sv
// EX-stage <-> M-extension unit signals: op request/flush from EX, stall/result back.
// master = execute stage, slave = ex_muldiv_unit.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] operand1_i;
  logic [XLEN-1:0] operand2_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, funct3_i, operand1_i, operand2_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, operand1_i, operand2_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// RV32M unit: MUL* in MUL_LATENCY+1 cycles, DIV* in XLEN+1 (1 for div-by-zero/overflow).
// Stalls EX via combinational busy_o; flush kills the op silently and leaves result_o alone.
module ex_muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input logic            clk,
  input logic            rst_n,
  ex_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] op_a, op_b;
  logic [1:0]      op_q;
  logic [XLEN-1:0] quo_q, rem_q, result_q;
  logic            neg_q, neg_r;
  logic [CW-1:0]   cnt;

  // accept-cycle decode
  logic            acc_signed, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, spec_res;

  always_comb begin
    acc_signed = ~bus.funct3_i[0];
    div_zero   = (bus.operand2_i == '0);
    div_ovf    = acc_signed && (bus.operand1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (bus.operand2_i == '1);
    a_mag      = (acc_signed && bus.operand1_i[XLEN-1]) ? -bus.operand1_i : bus.operand1_i;
    spec_res   = '0;
    if (div_zero)
      spec_res = bus.funct3_i[1] ? bus.operand1_i : '1;
    else
      spec_res = bus.funct3_i[1] ? '0 : bus.operand1_i;
  end

  // multiplier: both operands widened to 2*XLEN so one unsigned product covers all sign modes
  logic              a_sx, b_sx;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    a_sx    = op_a[XLEN-1] & ((op_q == 2'b01) || (op_q == 2'b10));
    b_sx    = op_b[XLEN-1] & (op_q == 2'b01);
    prod    = {{XLEN{a_sx}}, op_a} * {{XLEN{b_sx}}, op_b};
    mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // restoring divider step; quo_q shifts the dividend out as quotient bits shift in
  logic [XLEN-1:0] div_mag, rem_nx, quo_nx, q_fix, r_fix;
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;

  always_comb begin
    div_mag = (~op_q[0] && op_b[XLEN-1]) ? -op_b : op_b;
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, div_mag};
    ge      = ~diff[XLEN];
    rem_nx  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], ge};
    q_fix   = neg_q ? -quo_nx : quo_nx;
    r_fix   = neg_r ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      op_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
    end else if (bus.flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          op_a <= bus.operand1_i;
          op_b <= bus.operand2_i;
          op_q <= bus.funct3_i[1:0];
          cnt  <= '0;
          if (!bus.funct3_i[2]) begin
            state <= MUL;
          end else if (div_zero || div_ovf) begin
            result_q <= spec_res;
            state    <= DONE;
          end else begin
            quo_q <= a_mag;
            rem_q <= '0;
            neg_q <= acc_signed & (bus.operand1_i[XLEN-1] ^ bus.operand2_i[XLEN-1]);
            neg_r <= acc_signed & bus.operand1_i[XLEN-1];
            state <= DIV;
          end
        end
        MUL: begin
          if (cnt == CW'(MUL_LATENCY-1)) begin
            result_q <= mul_res;
            cnt      <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DIV: begin
          quo_q <= quo_nx;
          rem_q <= rem_nx;
          if (cnt == CW'(XLEN-1)) begin
            result_q <= op_q[1] ? r_fix : q_fix;
            cnt      <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o   = ((state == IDLE) && bus.start_i && !bus.flush_i) ||
                        (state == MUL) || (state == DIV);
  assign bus.done_o   = (state == DONE);
  assign bus.result_o = result_q;
endmodule
